rr_arbiter: RTL and testbench

//   Round-robin arbiter sharing one resource (e.g. a gate/ALU slice or LED bank) among N requesters.

---
 rtl/rr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_rr_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter granting one shared resource to one of N
// requesters at a time. Grant is registered, one-hot (or zero when idle) and
// rotates fairly via a search pointer that moves past each new winner.
// Optional feature macro: RR_TIMEOUT_EN. When defined, an owner that holds
// the grant for HOLD_MAX cycles while others wait is revoked and the revoke
// is flagged on preempt. When undefined, owners keep the grant as long as
// they request it and preempt is tied low.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 15,
  localparam int IW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          busy,
  output logic          preempt
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_gnt;
  logic [IW-1:0] r_gnt_id;
  logic          r_busy;
  logic [IW-1:0] r_ptr;

  logic [N-1:0]  w_req_m;
  logic          w_found;
  logic [IW-1:0] w_win_id;
  logic [N-1:0]  w_win_oh;
  logic [IW-1:0] w_ptr_next;
  logic          w_own_req;

  // (base + off) mod N for base < N and off < N.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // The current owner's bit is never a candidate: either it has dropped its
  // request, or it is being revoked and must hand over to someone else.
  assign w_req_m   = req & ~r_gnt;
  assign w_own_req = |(req & r_gnt);

  // Priority search starting at r_ptr and wrapping; walking downward so the
  // candidate closest to the pointer is the last (winning) assignment.
  always_comb begin
    w_found  = 1'b0;
    w_win_id = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_req_m[wrap_idx(r_ptr, k)]) begin
        w_found  = 1'b1;
        w_win_id = wrap_idx(r_ptr, k);
      end
    end
  end

  // One-hot decode of the winning index.
  for (genvar gi = 0; gi < N; gi++) begin : g_win_oh
    assign w_win_oh[gi] = (w_win_id == IW'(gi));
  end

  assign w_ptr_next = wrap_idx(w_win_id, 1);

`ifdef RR_TIMEOUT_EN
  logic [7:0] r_hold_cnt;
  logic       r_preempt;
  logic       w_expire;

  // Expiry compares with >= so a saturated counter keeps the owner eligible
  // for revoke the moment any other requester shows up.
  assign w_expire = (r_hold_cnt >= 8'(HOLD_MAX - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (HOLD_MAX == 0);
`endif

  // Arbiter FSM: tracks owner, pointer, and (optionally) hold time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_busy   <= 1'b0;
      r_ptr    <= '0;
`ifdef RR_TIMEOUT_EN
      r_hold_cnt <= '0;
      r_preempt  <= 1'b0;
`endif
    end else begin
`ifdef RR_TIMEOUT_EN
      r_preempt <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state  <= S_GRANT;
            r_gnt    <= w_win_oh;
            r_gnt_id <= w_win_id;
            r_busy   <= 1'b1;
            r_ptr    <= w_ptr_next;
`ifdef RR_TIMEOUT_EN
            r_hold_cnt <= '0;
`endif
          end
        end
        S_GRANT: begin
          if (!w_own_req) begin
            if (w_found) begin
              // Direct hand-over, no idle gap.
              r_gnt    <= w_win_oh;
              r_gnt_id <= w_win_id;
              r_ptr    <= w_ptr_next;
`ifdef RR_TIMEOUT_EN
              r_hold_cnt <= '0;
`endif
            end else begin
              r_state  <= S_IDLE;
              r_gnt    <= '0;
              r_gnt_id <= '0;
              r_busy   <= 1'b0;
            end
          end
`ifdef RR_TIMEOUT_EN
          else if (w_expire && w_found) begin
            // Owner still requesting but out of time: force rotation.
            r_gnt      <= w_win_oh;
            r_gnt_id   <= w_win_id;
            r_ptr      <= w_ptr_next;
            r_hold_cnt <= '0;
            r_preempt  <= 1'b1;
          end else if (r_hold_cnt < 8'(HOLD_MAX)) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
`endif
        end
        default: begin
          r_state  <= S_IDLE;
          r_gnt    <= '0;
          r_gnt_id <= '0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign gnt    = r_gnt;
  assign gnt_id = r_gnt_id;
  assign busy   = r_busy;
`ifdef RR_TIMEOUT_EN
  assign preempt = r_preempt;
`else
  assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed test of rr_arbiter (N=4, HOLD_MAX=4) with
// hand-computed expected grants. Timeout expectations follow RR_TIMEOUT_EN.
module tb_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       preempt;

  int n_cmp;
  int n_err;

  rr_arbiter #(
    .N        (4),
    .HOLD_MAX (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are then sampled on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    $display("t=%0t rst=%b req=%b gnt=%b id=%0d busy=%b preempt=%b",
             $time, rst, req, gnt, gnt_id, busy, preempt);
  endtask

  task automatic expect_gnt(input string tag, input logic [3:0] g, input logic [1:0] id);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".id"}, 32'(gnt_id), 32'(id));
    chk({tag, ".busy"}, 32'(busy), 32'(g != 4'b0000));
    chk({tag, ".pre"}, 32'(preempt), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    req   = 4'b1111;

    // Reset held for 2 cycles with all requests high
    tick(); expect_gnt("rst0", 4'b0000, 2'd0);
    tick(); expect_gnt("rst1", 4'b0000, 2'd0);
    rst = 1'b0;
    tick(); expect_gnt("first", 4'b0001, 2'd0);

    // Rotation: each owner drops for one cycle then re-raises
    req = 4'b1110; tick(); expect_gnt("rot1", 4'b0010, 2'd1);
    req = 4'b1111; tick(); expect_gnt("hold1", 4'b0010, 2'd1);
    req = 4'b1101; tick(); expect_gnt("rot2", 4'b0100, 2'd2);
    req = 4'b1111; tick(); expect_gnt("hold2", 4'b0100, 2'd2);
    req = 4'b1011; tick(); expect_gnt("rot3", 4'b1000, 2'd3);
    req = 4'b1111; tick(); expect_gnt("hold3", 4'b1000, 2'd3);
    req = 4'b0111; tick(); expect_gnt("rot0", 4'b0001, 2'd0);

    // Wrap/skip: bring owner to 2, then offer only 0 and 1
    req = 4'b1110; tick(); expect_gnt("ws1", 4'b0010, 2'd1);
    req = 4'b1101; tick(); expect_gnt("ws2", 4'b0100, 2'd2);
    req = 4'b0011; tick(); expect_gnt("wrap", 4'b0001, 2'd0);
    req = 4'b0010; tick(); expect_gnt("skip", 4'b0010, 2'd1);

    // Idle, then a 3-cycle pulse on req[1]
    req = 4'b0000; tick(); expect_gnt("idle0", 4'b0000, 2'd0);
    tick(); expect_gnt("idle1", 4'b0000, 2'd0);
    req = 4'b0010;
    expect_gnt("pulse_pre", 4'b0000, 2'd0);
    tick(); expect_gnt("pulse1", 4'b0010, 2'd1);
    tick(); expect_gnt("pulse2", 4'b0010, 2'd1);
    tick(); expect_gnt("pulse3", 4'b0010, 2'd1);
    req = 4'b0000;
    tick(); expect_gnt("pulse_end", 4'b0000, 2'd0);

    // Mid-grant reset with owner 3 (pointer is 2 here)
    req = 4'b1000; tick(); expect_gnt("own3", 4'b1000, 2'd3);
    rst = 1'b1;    tick(); expect_gnt("mrst", 4'b0000, 2'd0);
    rst = 1'b0;    tick(); expect_gnt("mrst_back", 4'b1000, 2'd3);
    req = 4'b0000; tick(); expect_gnt("mrst_idle", 4'b0000, 2'd0);

    // Timeout: req[0] and req[2] held, pointer at 0
    req = 4'b0101;
    tick(); expect_gnt("to1", 4'b0001, 2'd0);
`ifdef RR_TIMEOUT_EN
    tick(); expect_gnt("to2", 4'b0001, 2'd0);
    tick(); expect_gnt("to3", 4'b0001, 2'd0);
    tick(); expect_gnt("to4", 4'b0001, 2'd0);
    tick();
    chk("to_rev.gnt", 32'(gnt), 32'(4'b0100));
    chk("to_rev.id", 32'(gnt_id), 32'd2);
    chk("to_rev.pre", 32'(preempt), 32'd1);
    tick();
    chk("to_after.gnt", 32'(gnt), 32'(4'b0100));
    chk("to_after.pre", 32'(preempt), 32'd0);
`else
    for (int i = 0; i < 104; i++) begin
      tick();
      expect_gnt("nto_hold", 4'b0001, 2'd0);
    end
`endif
    req = 4'b0000; tick(); expect_gnt("final_idle", 4'b0000, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
